pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Instruction-cycle controller for the program counter register.
//  - Drives the PC's load and count controls: reset vector, fetch increment, jumps, call/return.
//  - Handshakes instruction fetch with memory and runs a FETCH/EXEC loop.
//  - Sits between the instruction decoder and the PC register.
// PARAMETERS
//  WIDTH        8  PC width in bits
//  RESET_VECTOR 0  address loaded into the PC after reset (WIDTH bits)
//  STACK_DEPTH  4  return-stack entries; used only with PC_STACK_EN; must be >= 1
// PORTS
//  clk            in   1      single clock, all state updates on posedge
//  reset          in   1      synchronous, active-high
//  pcValue        in   WIDTH  current PC register output
//  memReady       in   1      fetched instruction valid this cycle
//  stall          in   1      freeze sequencer (FETCH/EXEC only)
//  jumpReq        in   1      decoder: conditional jump in EXEC
//  jumpCond       in   1      condition flag; jump taken iff jumpReq&&jumpCond
//  jumpTarget     in   WIDTH  jump/call destination
//  callReq        in   1      decoder: call (push return address, jump)
//  retReq         in   1      decoder: return (pop into PC)
//  haltReq        in   1      decoder: halt
//  pcLoadData     out  WIDTH  value presented to the PC load input
//  nPcLoadEnable  out  1      active-low PC load strobe
//  pcCountEnable  out  1      PC increment strobe
//  fetchReq       out  1      request instruction at pcValue
//  irLoad         out  1      latch instruction register
//  halted         out  1      sequencer in HALTED
//  stackError     out  1      sticky call-overflow / ret-underflow flag
// BEHAVIOUR
//  States (2-bit): RESET_VEC=0, FETCH=1, EXEC=2, HALTED=3.
//  While reset=1:
//   - outputs idle: nPcLoadEnable=1, pcCountEnable=0, fetchReq=0, irLoad=0, halted=0.
//   - pcLoadData=RESET_VECTOR; stackError=0; stack pointer=0.
//   - next state RESET_VEC.
//  Reset mid-operation aborts any cycle; it takes effect on the next edge.
//  RESET_VEC: nPcLoadEnable=0, pcLoadData=RESET_VECTOR; -> FETCH. Exactly 1 cycle.
//  FETCH:
//   - fetchReq=1.
//   - memReady&&!stall: irLoad=1, pcCountEnable=1; -> EXEC.
//   - Otherwise hold, all strobes 0.
//  EXEC (Mealy outputs; one cycle unless stall):
//   - stall=1: hold, all strobes inactive.
//   - Priority: haltReq > retReq > callReq > jump-taken > none.
//   - halt: -> HALTED, PC untouched.
//   - ret: pop; load popped address; -> FETCH. Stack empty: stackError=1, -> HALTED, no load.
//   - call: push pcValue (already the return address); load jumpTarget; -> FETCH.
//     Stack full: stackError=1, -> HALTED, no push, no load.
//   - jump taken: load jumpTarget; -> FETCH.
//   - none: -> FETCH; PC unchanged (increment already done in FETCH).
//  HALTED: halted=1, all strobes inactive; leaves only via reset.
//  Invariant: nPcLoadEnable=0 and pcCountEnable=1 never asserted in the same cycle.
//  Minimum instruction time: 2 cycles (FETCH with memReady=1, then EXEC).
//  Addresses are plain WIDTH-bit values; PC wrap (all-ones -> 0) belongs to the counter, not this block.
// CONFIGURATION
//  PC_STACK_EN defined:
//   - STACK_DEPTH x WIDTH return stack; callReq/retReq behave as above.
//  PC_STACK_EN undefined:
//   - callReq/retReq ignored (EXEC treats them as not asserted).
//   - stackError tied 0; no stack storage.
// STRUCTURE
//  pc_seq_defs.vh (shared include):
//   - state encodings RESET_VEC/FETCH/EXEC/HALTED.
//   - stack pointer width = $clog2(STACK_DEPTH+1).
//  Sub-module pc_return_stack (push/pop/full/empty, synchronous reset).
//   - Instantiated only under PC_STACK_EN.
// TESTING
//  1 reset 3 cycles, release -> 1 cycle nPcLoadEnable=0, pcLoadData=0x00, then fetchReq=1.
//  2 FETCH with memReady low 3 cycles, then high -> irLoad and pcCountEnable pulse once; EXEC next cycle.
//  3 EXEC, jumpReq=1, jumpTarget=0x5A:
//   - jumpCond=1 -> load 0x5A.
//   - jumpCond=0 -> no load; back to FETCH.
//  4 PC_STACK_EN, pcValue=0x11:
//   - call 0x40 -> load 0x40; later ret -> load 0x11.
//   - ret on empty stack -> stackError=1, halted=1.
//  5 STACK_DEPTH=4: 5 nested calls -> 5th sets stackError=1, enters HALTED, no load.
//  6 stall=1 in EXEC with haltReq=1 -> hold; stall=0 -> HALTED. Reset in HALTED -> RESET_VEC, stackError=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer and its return stack.
package pc_sequencer_pkg;

  // Sequencer states; encoding is fixed at 2 bits.
  typedef enum logic [1:0] {
    ST_RESET_VEC = 2'd0,
    ST_FETCH     = 2'd1,
    ST_EXEC      = 2'd2,
    ST_HALTED    = 2'd3
  } seq_state_t;

  // Decoder requests seen in EXEC, already qualified (jump = jumpReq && jumpCond).
  typedef struct packed {
    logic halt;
    logic ret;
    logic call;
    logic jump;
  } exec_req_t;

  // Stack pointer width: must represent 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for call/ret; synchronous active-high reset clears the pointer.
module pc_return_stack
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned SP_W  = sp_width(DEPTH);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]  r_sp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_wr_idx = IDX_W'(r_sp);
  assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));
  assign o_full   = (r_sp == SP_W'(DEPTH));
  assign o_empty  = (r_sp == '0);
  assign o_top    = r_mem[w_rd_idx];

  // Pointer: push and pop are refused when full / empty respectively.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  // Storage write; contents need no reset because the pointer guards reads.
  always_ff @(posedge clk) begin
    if (!reset && i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller driving PC load/count with a FETCH/EXEC loop.
// Optional return stack for call/ret is enabled by defining PC_STACK_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned     STACK_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pcValue,
  input  logic             memReady,
  input  logic             stall,
  input  logic             jumpReq,
  input  logic             jumpCond,
  input  logic [WIDTH-1:0] jumpTarget,
  input  logic             callReq,
  input  logic             retReq,
  input  logic             haltReq,
  output logic [WIDTH-1:0] pcLoadData,
  output logic             nPcLoadEnable,
  output logic             pcCountEnable,
  output logic             fetchReq,
  output logic             irLoad,
  output logic             halted,
  output logic             stackError
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  exec_req_t        w_req;
  logic             w_push;
  logic             w_pop;
  logic             w_stack_fault;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_top;

`ifdef PC_STACK_EN
  logic r_stack_err;

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (pcValue),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky overflow/underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stack_err <= 1'b0;
    end else if (w_stack_fault) begin
      r_stack_err <= 1'b1;
    end
  end

  assign stackError = r_stack_err && !reset;
  assign w_req      = '{halt: haltReq, ret: retReq, call: callReq, jump: jumpReq && jumpCond};
`else
  logic w_unused_stack;

  assign w_full         = 1'b0;
  assign w_empty        = 1'b0;
  assign w_top          = '0;
  assign stackError     = 1'b0;
  assign w_req          = '{halt: haltReq, ret: 1'b0, call: 1'b0, jump: jumpReq && jumpCond};
  assign w_unused_stack = ^{callReq, retReq, pcValue, w_push, w_pop, w_stack_fault,
                            32'(STACK_DEPTH)};
`endif

  // State register; reset parks the sequencer on the reset-vector load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RESET_VEC;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and Mealy strobes; reset forces every strobe idle.
  always_comb begin
    w_next_state  = r_state;
    pcLoadData    = RESET_VECTOR;
    nPcLoadEnable = 1'b1;
    pcCountEnable = 1'b0;
    fetchReq      = 1'b0;
    irLoad        = 1'b0;
    halted        = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_stack_fault = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_RESET_VEC: begin
          nPcLoadEnable = 1'b0;
          w_next_state  = ST_FETCH;
        end
        ST_FETCH: begin
          fetchReq = 1'b1;
          if (memReady && !stall) begin
            irLoad        = 1'b1;
            pcCountEnable = 1'b1;
            w_next_state  = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            w_next_state = ST_FETCH;
            if (w_req.halt) begin
              w_next_state = ST_HALTED;
            end else if (w_req.ret) begin
              if (w_empty) begin
                w_stack_fault = 1'b1;
                w_next_state  = ST_HALTED;
              end else begin
                w_pop         = 1'b1;
                nPcLoadEnable = 1'b0;
                pcLoadData    = w_top;
              end
            end else if (w_req.call) begin
              if (w_full) begin
                w_stack_fault = 1'b1;
                w_next_state  = ST_HALTED;
              end else begin
                w_push        = 1'b1;
                nPcLoadEnable = 1'b0;
                pcLoadData    = jumpTarget;
              end
            end else if (w_req.jump) begin
              nPcLoadEnable = 1'b0;
              pcLoadData    = jumpTarget;
            end
          end
        end
        ST_HALTED: begin
          halted = 1'b1;
        end
        default: begin
          w_next_state = ST_RESET_VEC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps followed by random cycles,
// every cycle compared against a behavioural model with its own PC and return stack.
module tb_pc_sequencer;

  localparam int unsigned      W     = 8;
  localparam logic [W-1:0]     RV    = 8'h00;
  localparam int unsigned      DEPTH = 4;
  localparam int               PH_VEC   = 0;
  localparam int               PH_FETCH = 1;
  localparam int               PH_EXEC  = 2;
  localparam int               PH_HALT  = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] pcValue = '0;
  logic         memReady = 1'b0;
  logic         stall = 1'b0;
  logic         jumpReq = 1'b0;
  logic         jumpCond = 1'b0;
  logic [W-1:0] jumpTarget = '0;
  logic         callReq = 1'b0;
  logic         retReq = 1'b0;
  logic         haltReq = 1'b0;
  logic [W-1:0] pcLoadData;
  logic         nPcLoadEnable;
  logic         pcCountEnable;
  logic         fetchReq;
  logic         irLoad;
  logic         halted;
  logic         stackError;

  int n_checks = 0;
  int n_fail   = 0;

  int           m_ph  = PH_VEC;
  logic [W-1:0] m_pc  = '0;
  logic [W-1:0] m_stack [$];
  bit           m_err = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH        (W),
    .RESET_VECTOR (RV),
    .STACK_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pcValue       (pcValue),
    .memReady      (memReady),
    .stall         (stall),
    .jumpReq       (jumpReq),
    .jumpCond      (jumpCond),
    .jumpTarget    (jumpTarget),
    .callReq       (callReq),
    .retReq        (retReq),
    .haltReq       (haltReq),
    .pcLoadData    (pcLoadData),
    .nPcLoadEnable (nPcLoadEnable),
    .pcCountEnable (pcCountEnable),
    .fetchReq      (fetchReq),
    .irLoad        (irLoad),
    .halted        (halted),
    .stackError    (stackError)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after negedge, compare with the model, advance the model.
  // Returns before the next posedge so callers can add directed checks.
  task automatic step(input bit rst, input bit mr, input bit st, input bit jr, input bit jc,
                      input logic [W-1:0] jt, input bit cr, input bit rr, input bit hr);
    logic         e_nload, e_cnt, e_freq, e_irl, e_hlt, e_err;
    logic [W-1:0] e_data;
    bit           chk_data;
    int           nph;
    @(negedge clk);
    reset = rst; memReady = mr; stall = st; jumpReq = jr; jumpCond = jc;
    jumpTarget = jt; callReq = cr; retReq = rr; haltReq = hr; pcValue = m_pc;
    #1;
    e_nload = 1'b1; e_cnt = 1'b0; e_freq = 1'b0; e_irl = 1'b0; e_hlt = 1'b0;
    e_err = m_err && !rst; e_data = '0; chk_data = 1'b0; nph = m_ph;
    if (rst) begin
      chk_data = 1'b1; e_data = RV; nph = PH_VEC;
    end else begin
      case (m_ph)
        PH_VEC: begin
          e_nload = 1'b0; chk_data = 1'b1; e_data = RV; nph = PH_FETCH;
        end
        PH_FETCH: begin
          e_freq = 1'b1;
          if (mr && !st) begin e_irl = 1'b1; e_cnt = 1'b1; nph = PH_EXEC; end
        end
        PH_EXEC: begin
          if (!st) begin
            nph = PH_FETCH;
            if (hr) begin
              nph = PH_HALT;
`ifdef PC_STACK_EN
            end else if (rr) begin
              if (m_stack.size() == 0) begin
                m_err = 1'b1; nph = PH_HALT;
              end else begin
                e_nload = 1'b0; chk_data = 1'b1; e_data = m_stack.pop_back();
              end
            end else if (cr) begin
              if (m_stack.size() >= DEPTH) begin
                m_err = 1'b1; nph = PH_HALT;
              end else begin
                m_stack.push_back(m_pc);
                e_nload = 1'b0; chk_data = 1'b1; e_data = jt;
              end
`endif
            end else if (jr && jc) begin
              e_nload = 1'b0; chk_data = 1'b1; e_data = jt;
            end
          end
        end
        default: e_hlt = 1'b1;
      endcase
    end
    if (rst) begin
      m_stack.delete();
      m_err = 1'b0;
    end
    check1("nPcLoadEnable", nPcLoadEnable, e_nload);
    check1("pcCountEnable", pcCountEnable, e_cnt);
    check1("fetchReq", fetchReq, e_freq);
    check1("irLoad", irLoad, e_irl);
    check1("halted", halted, e_hlt);
    check1("stackError", stackError, e_err);
    check1("load_count_overlap", !nPcLoadEnable && pcCountEnable, 1'b0);
    if (chk_data) check8("pcLoadData", pcLoadData, e_data);
    if (!e_nload) m_pc = e_data;
    else if (e_cnt) m_pc = m_pc + W'(1);
    m_ph = nph;
  endtask

  task automatic idle(input bit mr);
    step(1'b0, mr, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset for 3 cycles, then one reset-vector load, then fetch.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check1("t1_reset_idle_load", nPcLoadEnable, 1'b1);
    idle(1'b0);
    check1("t1_vec_load", nPcLoadEnable, 1'b0);
    check8("t1_vec_data", pcLoadData, 8'h00);
    idle(1'b0);
    check1("t1_fetch_req", fetchReq, 1'b1);

    // FETCH with memReady low, then high.
    idle(1'b0);
    idle(1'b0);
    check1("t2_no_irload", irLoad, 1'b0);
    idle(1'b1);
    check1("t2_irload", irLoad, 1'b1);
    check1("t2_count", pcCountEnable, 1'b1);

    // Conditional jump taken, then not taken.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check1("t3_jump_load", nPcLoadEnable, 1'b0);
    check8("t3_jump_data", pcLoadData, 8'h5A);
    idle(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    check1("t3_nojump", nPcLoadEnable, 1'b1);
    idle(1'b0);
    check1("t3_back_fetch", fetchReq, 1'b1);

    // Stall in EXEC holds a pending halt.
    idle(1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check1("t6_stall_hold", halted, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check1("t6_halted", halted, 1'b1);
    idle(1'b1);
    check1("t6_halted_sticky", halted, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check1("t6_reset_err", stackError, 1'b0);
    idle(1'b0);
    check1("t6_revec", nPcLoadEnable, 1'b0);

`ifdef PC_STACK_EN
    // Call from 0x11 to 0x40, return to 0x11, then return on empty stack.
    idle(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0);
    check8("t4_call_data", pcLoadData, 8'h40);
    idle(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check1("t4_ret_load", nPcLoadEnable, 1'b0);
    check8("t4_ret_data", pcLoadData, 8'h11);
    idle(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check1("t4_underflow_noload", nPcLoadEnable, 1'b1);
    idle(1'b0);
    check1("t4_underflow_err", stackError, 1'b1);
    check1("t4_underflow_halt", halted, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Five nested calls into a 4-deep stack.
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'(8'h20 + i), 1'b1, 1'b0, 1'b0);
      check1("t5_call_load", nPcLoadEnable, (i == 4) ? 1'b1 : 1'b0);
    end
    idle(1'b0);
    check1("t5_overflow_err", stackError, 1'b1);
    check1("t5_overflow_halt", halted, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check1("t5_reset_err", stackError, 1'b0);
    idle(1'b0);
`endif

    // Random traffic checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           W'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
